// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with store buffer, forwarding and multi-cycle RAM drain
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int DEPTH     = 4,
  parameter int WR_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memWr,
  input  logic [1:0]  dataSize,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        bufferEmpty,
  output logic        misalign
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int CNT_W   = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FULL   = COUNT_W'(DEPTH);

  typedef enum logic {IDLE, WRITE} drainState_t;

  // Backing RAM and store-buffer storage (not reset: contents survive resetN)
  logic [31:0]          ram     [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] bufAddr [DEPTH];
  logic [31:0]          bufData [DEPTH];
  logic [3:0]           bufEn   [DEPTH];

  drainState_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [COUNT_W-1:0]   count;
  logic [COUNT_W-1:0]   countNext;
  logic [PTR_W-1:0]     headPtr;
  logic [PTR_W-1:0]     tailPtr;

  logic [ADDR_BITS-1:0] wordIdx;
  logic [31:0]          storeData;
  logic [3:0]           storeEn;
  logic                 aligned;
  logic                 doEnq;
  logic                 doDeq;
  logic                 unusedAddrBits;

  // Upper address bits alias onto the RAM; they are deliberately dropped here
  assign wordIdx        = address[ADDR_BITS+1:2];
  assign unusedAddrBits = ^address[31:ADDR_BITS+2];

  assign memStall    = (count == FULL);
  assign bufferEmpty = (count == '0);
  assign doEnq       = memWr & aligned & ~memStall;
  assign doDeq       = (state == WRITE) && (cnt == '0);

  // Big-endian lane placement: byteEn bit 3 is lane 0 (bits 31:24), bit 0 is lane 3
  always_comb begin
    storeData = writeData;
    storeEn   = 4'b1111;
    aligned   = 1'b1;
    case (dataSize)
      2'b00: begin
        storeData = {4{writeData[7:0]}};
        storeEn   = 4'b1000 >> address[1:0];
      end
      2'b01: begin
        storeData = {2{writeData[15:0]}};
        storeEn   = address[1] ? 4'b0011 : 4'b1100;
        aligned   = ~address[0];
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Occupancy after this edge; a same-edge enqueue and dequeue cancel out
  always_comb begin
    countNext = count;
    if (doEnq && !doDeq) begin
      countNext = count + COUNT_W'(1);
    end else if (!doEnq && doDeq) begin
      countNext = count - COUNT_W'(1);
    end
  end

  // Queue bookkeeping: occupancy and FIFO pointers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count   <= '0;
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      count <= countNext;
      if (doEnq) tailPtr <= tailPtr + PTR_W'(1);
      if (doDeq) headPtr <= headPtr + PTR_W'(1);
    end
  end

  // Drain FSM: wait WR_CYCLES edges per entry, commit the head when cnt hits zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= WRITE;
            cnt   <= RELOAD;
          end
        end
        WRITE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (countNext != '0) begin
            cnt <= RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky misaligned-store flag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      misalign <= 1'b0;
    end else if (memWr && !aligned) begin
      misalign <= 1'b1;
    end
  end

  // Store-buffer entry write at the tail
  always_ff @(posedge clk) begin
    if (doEnq) begin
      bufAddr[tailPtr] <= wordIdx;
      bufData[tailPtr] <= storeData;
      bufEn[tailPtr]   <= storeEn;
    end
  end

  // RAM commit of the head entry, only its enabled lanes
  always_ff @(posedge clk) begin
    if (doDeq) begin
      for (int j = 0; j < 4; j++) begin
        if (bufEn[headPtr][j]) begin
          ram[bufAddr[headPtr]][8*j +: 8] <= bufData[headPtr][8*j +: 8];
        end
      end
    end
  end

  // Load path: RAM word overlaid by matching pending entries, oldest first so newest wins
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot     = '0;
    readData = ram[wordIdx];
    for (int i = 0; i < DEPTH; i++) begin
      slot = headPtr + PTR_W'(i);
      if ((COUNT_W'(i) < count) && (bufAddr[slot] == wordIdx)) begin
        for (int j = 0; j < 4; j++) begin
          if (bufEn[slot][j]) begin
            readData[8*j +: 8] = bufData[slot][8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int AB    = 10;
  localparam int DEPTH = 4;
  localparam int WR    = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memWr = 1'b0;
  logic [1:0]  dataSize = 2'b10;
  logic [31:0] readData;
  logic        memStall;
  logic        bufferEmpty;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  dmem_responder #(.ADDR_BITS(AB), .DEPTH(DEPTH), .WR_CYCLES(WR)) dut (
    .clk(clk), .resetN(resetN), .address(address), .writeData(writeData),
    .memWr(memWr), .dataSize(dataSize), .readData(readData),
    .memStall(memStall), .bufferEmpty(bufferEmpty), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: architectural RAM plus a list of pending stores with their commit edge
  typedef struct {
    int          commitEdge;
    int          idx;
    logic [31:0] data;
    logic [3:0]  en;
  } pend_t;

  pend_t       q[$];
  logic [31:0] ramM [1024];
  bit   [3:0]  ramV [1024];
  bit          misM = 1'b0;
  int          edgeN = 0;

  function automatic logic [31:0] laneMask(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

  function automatic bit isMisaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp, input logic [31:0] msk);
    vectors++;
    if ((act & msk) !== (exp & msk)) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, msk, $time);
    end
  endtask

  // Model update on every edge; async reset discards pending stores
  initial begin
    pend_t e;
    bit    acc;
    int    sh;
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        q.delete();
        misM = 1'b0;
      end else begin
        edgeN++;
        acc = 1'b0;
        if (memWr) begin
          if (isMisaligned(address, dataSize)) begin
            misM = 1'b1;
          end else if (q.size() < DEPTH) begin
            e.idx = int'(address[AB+1:2]);
            if (dataSize == 2'b00) begin
              sh     = 3 - int'(address[1:0]);
              e.data = {24'b0, writeData[7:0]} << (8 * sh);
              e.en   = 4'b0001 << sh;
            end else if (dataSize == 2'b01) begin
              sh     = address[1] ? 0 : 2;
              e.data = {16'b0, writeData[15:0]} << (8 * sh);
              e.en   = 4'b0011 << sh;
            end else begin
              e.data = writeData;
              e.en   = 4'b1111;
            end
            e.commitEdge = (q.size() > 0) ? q[$].commitEdge + WR : edgeN + WR + 1;
            acc = 1'b1;
          end
        end
        while (q.size() > 0 && q[0].commitEdge == edgeN) begin
          ramM[q[0].idx] = (ramM[q[0].idx] & ~laneMask(q[0].en)) | (q[0].data & laneMask(q[0].en));
          ramV[q[0].idx] = ramV[q[0].idx] | q[0].en;
          void'(q.pop_front());
        end
        if (acc) q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle
  initial begin
    logic [31:0] expD;
    logic [31:0] msk;
    int          idx;
    forever begin
      @(negedge clk);
      idx  = int'(address[AB+1:2]);
      expD = ramM[idx];
      msk  = laneMask(ramV[idx]);
      foreach (q[k]) begin
        if (q[k].idx == idx) begin
          expD = (expD & ~laneMask(q[k].en)) | (q[k].data & laneMask(q[k].en));
          msk  = msk | laneMask(q[k].en);
        end
      end
      if (msk != '0) check32("model readData", readData, expD, msk);
      check32("model memStall", {31'b0, memStall}, {31'b0, q.size() == DEPTH}, 32'h1);
      check32("model bufferEmpty", {31'b0, bufferEmpty}, {31'b0, q.size() == 0}, 32'h1);
      check32("model misalign", {31'b0, misalign}, {31'b0, misM}, 32'h1);
    end
  end

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, output int edges);
    bit stalledNow;
    bit done;
    address   = a;
    writeData = d;
    dataSize  = sz;
    memWr     = 1'b1;
    edges     = 0;
    done      = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      stalledNow = memStall;
      @(posedge clk);
      #1;
      edges++;
      if (!stalledNow) done = 1'b1;
    end
    memWr = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL store timeout: addr %h never accepted", a);
    end
  endtask

  task automatic waitEmpty(output int n);
    n = 0;
    while (!bufferEmpty && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bufferEmpty) begin
      vectors++;
      miscompares++;
      $display("FAIL drain timeout: bufferEmpty still %0d after %0d edges", bufferEmpty, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ed;
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check32("reset bufferEmpty", {31'b0, bufferEmpty}, 32'h1, 32'h1);
    check32("reset memStall", {31'b0, memStall}, 32'h0, 32'h1);
    check32("reset misalign", {31'b0, misalign}, 32'h0, 32'h1);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Word store forwarded, then drained after 4 edges
    doStore(32'h40, 32'hDEADBEEF, 2'b10, ed);
    address = 32'h40;
    #1;
    check32("fwd word 0x40", readData, 32'hDEADBEEF, '1);
    waitEmpty(n);
    check32("drain latency", n, 32'd4, '1);
    check32("ram word 0x40", readData, 32'hDEADBEEF, '1);

    // Byte and half merge over an existing RAM word
    doStore(32'h80, 32'h11223344, 2'b10, ed);
    waitEmpty(n);
    doStore(32'h81, 32'h000000AA, 2'b00, ed);
    doStore(32'h82, 32'h0000BBCC, 2'b01, ed);
    address = 32'h80;
    #1;
    check32("merge fwd 0x80", readData, 32'h11AABBCC, '1);
    waitEmpty(n);
    check32("merge ram 0x80", readData, 32'h11AABBCC, '1);

    // Back-to-back stores to the same word: newest wins, drains 3 edges apart
    doStore(32'h10, 32'h1, 2'b10, ed);
    doStore(32'h10, 32'h2, 2'b10, ed);
    address = 32'h10;
    #1;
    check32("newest wins 0x10", readData, 32'h2, '1);
    waitEmpty(n);
    check32("two drains edges", n, 32'd6, '1);
    check32("ram 0x10", readData, 32'h2, '1);

    // Fill the buffer; fifth store waits for a slot
    for (int i = 0; i < 4; i++) doStore(32'h100 + 4*i, 32'hC0DE0000 + i, 2'b10, ed);
    check32("full stall", {31'b0, memStall}, 32'h1, 32'h1);
    doStore(32'h110, 32'hC0DE0004, 2'b10, ed);
    check32("held store edges", ed, 32'd2, '1);
    waitEmpty(n);
    for (int i = 0; i < 5; i++) begin
      address = 32'h100 + 4*i;
      #1;
      check32("readback fill", readData, 32'hC0DE0000 + i, '1);
    end
    // Alias: upper address bits ignored
    address = 32'h8000_0104;
    #1;
    check32("alias 0x104", readData, 32'hC0DE0001, '1);

    // Misaligned half store
    doStore(32'h43, 32'h00001234, 2'b01, ed);
    check32("misalign set", {31'b0, misalign}, 32'h1, 32'h1);
    check32("misalign empty", {31'b0, bufferEmpty}, 32'h1, 32'h1);
    check32("misalign no stall", {31'b0, memStall}, 32'h0, 32'h1);
    address = 32'h40;
    #1;
    check32("misalign untouched", readData, 32'hDEADBEEF, '1);

    // Reset mid-WRITE abandons pending stores
    doStore(32'h200, 32'hA0A0A0A0, 2'b10, ed);
    doStore(32'h204, 32'hB0B0B0B0, 2'b10, ed);
    waitEmpty(n);
    doStore(32'h200, 32'h55555555, 2'b10, ed);
    doStore(32'h204, 32'h66666666, 2'b10, ed);
    @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check32("async rst empty", {31'b0, bufferEmpty}, 32'h1, 32'h1);
    check32("async rst stall", {31'b0, memStall}, 32'h0, 32'h1);
    check32("async rst misalign", {31'b0, misalign}, 32'h0, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    address = 32'h200;
    #1;
    check32("old data 0x200", readData, 32'hA0A0A0A0, '1);
    address = 32'h204;
    #1;
    check32("old data 0x204", readData, 32'hB0B0B0B0, '1);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
